// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use interlock unit with an internal scoreboard of
// in-flight destination tags (entry 1 = EX, entry NSTAGE = WB).
module forwarding_hazard_unit #(
    parameter int NREAD            = 4,
    parameter int NSTAGE           = 3,
    parameter int AW               = 4,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SELW             = $clog2(NSTAGE + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREAD*AW-1:0]     in_add,
    input  logic [NREAD-1:0]        rd,
    input  logic                    issue_wr,
    input  logic [AW-1:0]           issue_addr,
    input  logic                    issue_load,
    input  logic                    issue_valid,
    input  logic                    flush,
    input  logic                    ext_hold,
    output logic [NREAD*SELW-1:0]   mux_sel,
    output logic                    freeze,
    output logic [15:0]             stall_count
);

    logic [NSTAGE:1] v_q, v_d;
    logic [NSTAGE:1] ld_q, ld_d;
    logic [AW-1:0]   addr_q [1:NSTAGE];
    logic [AW-1:0]   addr_d [1:NSTAGE];
    logic [15:0]     stall_count_q, stall_count_d;
    logic [NREAD-1:0] stall;
    logic [NREAD-1:0] found;

    // Youngest matching stage wins; older matches are masked by found[i].
    always_comb begin
        mux_sel = '0;
        stall   = '0;
        found   = '0;
        for (int i = 0; i < NREAD; i++) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                if (!found[i] && rd[i] && v_q[k] && (addr_q[k] == in_add[i*AW +: AW])) begin
                    found[i] = 1'b1;
                    if (ld_q[k] && (k < LOAD_READY_STAGE)) begin
                        stall[i] = 1'b1;
                    end else begin
                        mux_sel[i*SELW +: SELW] = SELW'(k);
                    end
                end
            end
        end
    end

    assign freeze      = |stall;
    assign stall_count = stall_count_q;

    // A frozen or flushed decode slot enters the pipe as a bubble.
    always_comb begin
        v_d           = v_q;
        ld_d          = ld_q;
        addr_d        = addr_q;
        stall_count_d = stall_count_q;
        if (!ext_hold) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                v_d[k]    = v_q[k-1];
                ld_d[k]   = ld_q[k-1];
                addr_d[k] = addr_q[k-1];
            end
            if (freeze || flush) begin
                v_d[1]    = 1'b0;
                ld_d[1]   = 1'b0;
                addr_d[1] = '0;
            end else begin
                v_d[1]    = issue_valid & issue_wr;
                ld_d[1]   = issue_load;
                addr_d[1] = issue_addr;
            end
            if (freeze && (stall_count_q != 16'hFFFF)) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q           <= '0;
            ld_q          <= '0;
            stall_count_q <= '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                addr_q[k] <= '0;
            end
        end else begin
            v_q           <= v_d;
            ld_q          <= ld_d;
            stall_count_q <= stall_count_d;
            for (int k = 1; k <= NSTAGE; k++) begin
                addr_q[k] <= addr_d[k];
            end
        end
    end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: default configuration, a
// 4-stage/load-ready-3 variant, and a 15-stage variant for counter saturation.
module tb_forwarding_hazard_unit;

    localparam int NREAD = 4;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_add;
    logic [3:0]  rd;
    logic        issue_wr, issue_load, issue_valid, flush, ext_hold;
    logic [3:0]  issue_addr;

    logic [7:0]  mux_sel;
    logic        freeze;
    logic [15:0] stall_count;
    logic [11:0] p4_mux_sel;
    logic        p4_freeze;
    logic [15:0] p4_stall_count;

    logic        sat_rst;
    logic [15:0] sat_in_add;
    logic [3:0]  sat_rd;
    logic        sat_issue_wr, sat_issue_load, sat_issue_valid, sat_flush, sat_ext_hold;
    logic [3:0]  sat_issue_addr;
    logic [15:0] sat_mux_sel;
    logic        sat_freeze;
    logic [15:0] sat_stall_count;

    int checks   = 0;
    int failures = 0;

    forwarding_hazard_unit u_dut (
        .clk(clk), .rst(rst), .in_add(in_add), .rd(rd),
        .issue_wr(issue_wr), .issue_addr(issue_addr), .issue_load(issue_load),
        .issue_valid(issue_valid), .flush(flush), .ext_hold(ext_hold),
        .mux_sel(mux_sel), .freeze(freeze), .stall_count(stall_count)
    );

    forwarding_hazard_unit #(.NSTAGE(4), .LOAD_READY_STAGE(3)) u_p4 (
        .clk(clk), .rst(rst), .in_add(in_add), .rd(rd),
        .issue_wr(issue_wr), .issue_addr(issue_addr), .issue_load(issue_load),
        .issue_valid(issue_valid), .flush(flush), .ext_hold(ext_hold),
        .mux_sel(p4_mux_sel), .freeze(p4_freeze), .stall_count(p4_stall_count)
    );

    forwarding_hazard_unit #(.NSTAGE(15), .LOAD_READY_STAGE(15)) u_sat (
        .clk(clk), .rst(sat_rst), .in_add(sat_in_add), .rd(sat_rd),
        .issue_wr(sat_issue_wr), .issue_addr(sat_issue_addr), .issue_load(sat_issue_load),
        .issue_valid(sat_issue_valid), .flush(sat_flush), .ext_hold(sat_ext_hold),
        .mux_sel(sat_mux_sel), .freeze(sat_freeze), .stall_count(sat_stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_add      = '0;
        rd          = '0;
        issue_wr    = 1'b0;
        issue_addr  = '0;
        issue_load  = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
        ext_hold    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        step();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] addr, input logic load);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_addr  = addr;
        issue_load  = load;
    endtask

    task automatic set_read(input int port, input logic [3:0] addr);
        in_add[port*AW +: AW] = addr;
        rd[port]              = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_add      = 16'($urandom);
            rd          = 4'($urandom);
            issue_wr    = 1'($urandom);
            issue_addr  = 4'($urandom);
            issue_load  = 1'($urandom);
            issue_valid = 1'($urandom);
            flush       = 1'($urandom);
            ext_hold    = 1'($urandom);
            step();
            checks++;
            if (mux_sel !== 8'd0 || freeze !== 1'b0 || p4_mux_sel !== 12'd0 || p4_freeze !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_outputs: got sel=%0h freeze=%0b p4sel=%0h p4freeze=%0b expected all 0",
                         mux_sel, freeze, p4_mux_sel, p4_freeze);
            end
        end
        set_idle();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (stall_count !== 16'd0 || p4_stall_count !== 16'd0 || freeze !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_count: got count=%0d p4count=%0d freeze=%0b expected 0 0 0",
                     stall_count, p4_stall_count, freeze);
        end
    endtask

    task automatic test_alu_chain();
        do_reset();
        issue(4'd3, 1'b0);
        set_read(0, 4'd3);
        #1;
        checks++;
        if (mux_sel[1:0] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL alu_same_cycle: got %0d expected 0", mux_sel[1:0]);
        end
        step();
        set_idle();
        set_read(0, 4'd3);
        in_add[2*AW +: AW] = 4'd3;
        #1;
        checks++;
        if (mux_sel[1:0] !== 2'd1) begin
            failures++;
            $display("[TB] FAIL alu_stage1: got %0d expected 1", mux_sel[1:0]);
        end
        checks++;
        if (mux_sel[5:4] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL rd_off_port: got %0d expected 0", mux_sel[5:4]);
        end
        step();
        checks++;
        if (mux_sel[1:0] !== 2'd2) begin
            failures++;
            $display("[TB] FAIL alu_stage2: got %0d expected 2", mux_sel[1:0]);
        end
        step();
        checks++;
        if (mux_sel[1:0] !== 2'd3) begin
            failures++;
            $display("[TB] FAIL alu_stage3: got %0d expected 3", mux_sel[1:0]);
        end
        step();
        checks++;
        if (mux_sel[1:0] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL alu_retired: got %0d expected 0", mux_sel[1:0]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        issue(4'd5, 1'b1);
        step();
        set_idle();
        set_read(1, 4'd5);
        set_read(3, 4'd5);
        #1;
        checks++;
        if (freeze !== 1'b1 || mux_sel[3:2] !== 2'd0 || mux_sel[7:6] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL load_use_freeze: got freeze=%0b sel1=%0d sel3=%0d expected 1 0 0",
                     freeze, mux_sel[3:2], mux_sel[7:6]);
        end
        step();
        checks++;
        if (freeze !== 1'b0 || mux_sel[3:2] !== 2'd2 || mux_sel[7:6] !== 2'd2) begin
            failures++;
            $display("[TB] FAIL load_use_fwd: got freeze=%0b sel1=%0d sel3=%0d expected 0 2 2",
                     freeze, mux_sel[3:2], mux_sel[7:6]);
        end
        checks++;
        if (stall_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL load_use_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_param_stage4();
        do_reset();
        issue(4'd5, 1'b1);
        step();
        set_idle();
        set_read(0, 4'd5);
        #1;
        checks++;
        if (p4_freeze !== 1'b1 || p4_mux_sel[2:0] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL p4_freeze1: got freeze=%0b sel=%0d expected 1 0", p4_freeze, p4_mux_sel[2:0]);
        end
        step();
        checks++;
        if (p4_freeze !== 1'b1 || p4_mux_sel[2:0] !== 3'd0) begin
            failures++;
            $display("[TB] FAIL p4_freeze2: got freeze=%0b sel=%0d expected 1 0", p4_freeze, p4_mux_sel[2:0]);
        end
        step();
        checks++;
        if (p4_freeze !== 1'b0 || p4_mux_sel[2:0] !== 3'd3 || p4_stall_count !== 16'd2) begin
            failures++;
            $display("[TB] FAIL p4_fwd: got freeze=%0b sel=%0d count=%0d expected 0 3 2",
                     p4_freeze, p4_mux_sel[2:0], p4_stall_count);
        end
    endtask

    task automatic test_priority();
        do_reset();
        issue(4'd2, 1'b0);
        step();
        issue(4'd2, 1'b0);
        step();
        set_idle();
        set_read(0, 4'd2);
        #1;
        checks++;
        if (mux_sel[1:0] !== 2'd1 || freeze !== 1'b0) begin
            failures++;
            $display("[TB] FAIL priority_alu: got sel=%0d freeze=%0b expected 1 0", mux_sel[1:0], freeze);
        end
        do_reset();
        issue(4'd2, 1'b0);
        step();
        issue(4'd2, 1'b1);
        step();
        set_idle();
        set_read(0, 4'd2);
        #1;
        checks++;
        if (mux_sel[1:0] !== 2'd0 || freeze !== 1'b1) begin
            failures++;
            $display("[TB] FAIL priority_load: got sel=%0d freeze=%0b expected 0 1", mux_sel[1:0], freeze);
        end
    endtask

    task automatic test_hold_flush();
        do_reset();
        issue(4'd5, 1'b1);
        step();
        set_idle();
        set_read(0, 4'd5);
        ext_hold = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++;
            if (freeze !== 1'b1 || stall_count !== 16'd0) begin
                failures++;
                $display("[TB] FAIL hold_freeze: cycle %0d got freeze=%0b count=%0d expected 1 0",
                         n, freeze, stall_count);
            end
            step();
        end
        ext_hold = 1'b0;
        #1;
        checks++;
        if (freeze !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_static: got freeze=%0b expected 1", freeze);
        end
        step();
        checks++;
        if (freeze !== 1'b0 || mux_sel[1:0] !== 2'd2 || stall_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL hold_release: got freeze=%0b sel=%0d count=%0d expected 0 2 1",
                     freeze, mux_sel[1:0], stall_count);
        end
        do_reset();
        issue(4'd7, 1'b1);
        flush = 1'b1;
        step();
        set_idle();
        set_read(0, 4'd7);
        for (int n = 0; n < 2; n++) begin
            #1;
            checks++;
            if (mux_sel[1:0] !== 2'd0 || freeze !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush_bubble: cycle %0d got sel=%0d freeze=%0b expected 0 0",
                         n, mux_sel[1:0], freeze);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        issue(4'd5, 1'b1);
        step();
        set_idle();
        set_read(2, 4'd5);
        #1;
        checks++;
        if (freeze !== 1'b1) begin
            failures++;
            $display("[TB] FAIL async_pre: got freeze=%0b expected 1", freeze);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (freeze !== 1'b0 || mux_sel !== 8'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got freeze=%0b sel=%0h expected 0 0", freeze, mux_sel);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        sat_in_add      = 16'h0005;
        sat_rd          = 4'b0001;
        sat_issue_wr    = 1'b1;
        sat_issue_addr  = 4'd5;
        sat_issue_load  = 1'b1;
        sat_issue_valid = 1'b1;
        sat_flush       = 1'b0;
        sat_ext_hold    = 1'b0;
        step();
        sat_rst = 1'b0;
        repeat (15) step();
        checks++;
        if (sat_mux_sel[3:0] !== 4'd15 || sat_freeze !== 1'b0 || sat_stall_count !== 16'd14) begin
            failures++;
            $display("[TB] FAIL sat_period: got sel=%0d freeze=%0b count=%0d expected 15 0 14",
                     sat_mux_sel[3:0], sat_freeze, sat_stall_count);
        end
        step();
        checks++;
        if (sat_mux_sel !== 16'd0 || sat_freeze !== 1'b1 || sat_stall_count !== 16'd14) begin
            failures++;
            $display("[TB] FAIL sat_reissue: got sel=%0h freeze=%0b count=%0d expected 0 1 14",
                     sat_mux_sel, sat_freeze, sat_stall_count);
        end
        repeat (71000) step();
        checks++;
        if (sat_stall_count !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL sat_count: got %0h expected ffff", sat_stall_count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        sat_rst = 1'b1;
        set_idle();
        sat_in_add      = '0;
        sat_rd          = '0;
        sat_issue_wr    = 1'b0;
        sat_issue_addr  = '0;
        sat_issue_load  = 1'b0;
        sat_issue_valid = 1'b0;
        sat_flush       = 1'b0;
        sat_ext_hold    = 1'b0;
        $display("[TB] starting forwarding_hazard_unit bench");
        test_reset();
        test_alu_chain();
        test_load_use();
        test_param_stage4();
        test_priority();
        test_hold_flush();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Parametrised forwarding and load-use interlock unit for the pipelined ARM core. It replaces the purely combinational per-port match logic with an internal scoreboard. The scoreboard is a shift register of in-flight destination tags, one entry per post-decode stage, which the unit updates itself from the decode-stage issue information. Every cycle it drives per-read-port bypass selects, a pipeline freeze with automatic bubble insertion, and a saturating stall-cycle counter. It sits beside the decode/register-read stage.

## Interface
Parameters:
- NREAD, 4: number of register read ports checked.
- NSTAGE, 3: tracked post-decode stages (1 = EX, youngest; NSTAGE = WB, oldest).
- AW, 4: register address width.
- LOAD_READY_STAGE, 2: first stage index at which load data can be forwarded. Range 1..NSTAGE.
- SELW, $clog2(NSTAGE+1): mux select width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_add  in  NREAD*AW  read addresses; port i at [i*AW +: AW].
- rd  in  NREAD  read-port-used flags.
- issue_wr  in  1  decode instruction writes a register.
- issue_addr  in  AW  decode instruction destination.
- issue_load  in  1  decode instruction is a load.
- issue_valid  in  1  decode slot holds a real instruction.
- flush  in  1  kill the decode instruction (branch taken).
- ext_hold  in  1  global pipeline hold (memory wait).
- mux_sel  out  NREAD*SELW  per port: 0 = register file, k = forward from stage k.
- freeze  out  1  stall decode and fetch this cycle.
- stall_count  out  16  saturating count of interlock cycles.

## Operation
- Scoreboard entry k (1..NSTAGE) holds {v, addr, ld}.
- Match for port i at stage k: rd[i] & v[k] & (addr[k] == in_add[i]).
- Priority: the lowest matching k wins (youngest producer).
- Port i when no match: mux_sel = 0.
- Port i when the winning entry has ld=1 and k < LOAD_READY_STAGE: stall_i = 1 and mux_sel = 0.
- Port i otherwise: mux_sel = k.
- freeze = OR of stall_i. This output is combinational from registered state plus the current inputs.
- Pipe advance on a clock edge, in priority order:
  - ext_hold=1: all entries hold.
  - Otherwise entry k+1 <= entry k for k = 1..NSTAGE-1, and entry NSTAGE retires.
- Entry 1 load value when advancing:
  - freeze=1 or flush=1: bubble (v=0).
  - Otherwise: {issue_valid & issue_wr, issue_addr, issue_load}.
- flush has no effect while ext_hold=1. Upstream holds flush until the hold is released.
- stall_count increments when freeze=1 and ext_hold=0. It saturates at 16'hFFFF.

## Timing
- Reset clears all v, ld and addr to 0 and stall_count to 0. With all entries invalid, mux_sel = 0 and freeze = 0.
- Bypass select and freeze have zero-cycle latency relative to in_add and rd. The scoreboard reflects an issued instruction from the next edge.
- Load-use with default parameters gives exactly one freeze cycle. The load moves to stage 2 behind the inserted bubble, so the next cycle selects 2.
- With LOAD_READY_STAGE = L, a dependent instruction issued directly behind a load is frozen L-1 cycles.
- A simultaneous match in several stages forwards from the youngest stage only. Older matches are ignored, even if the youngest is a stalled load.
- rd[i]=0 never matches and never stalls.
- During ext_hold, freeze still evaluates, but the scoreboard and stall_count do not change.
- Reset asserted mid-freeze clears the scoreboard immediately (asynchronous), so freeze drops the same cycle.

## Test plan
- Reset: assert rst with random inputs; all entries invalid → mux_sel = 0 and freeze = 0. After release with no issues, stall_count = 0.
- ALU chain: issue wr r3 (non-load), then next cycle read port 0 = r3 → mux_sel[0] = 1. One cycle later → 2, then 3, then 0 after retirement.
- Load-use: issue load r5, then read ports 1 and 3 = r5 → freeze = 1 for one cycle with both selects 0. The next cycle gives selects = 2, freeze = 0, and stall_count = 1.
- Priority: issue wr r2 in two consecutive cycles, then read r2 → select 1, not 2. Repeat with the younger writer a load → freeze = 1.
- Hold and flush:
  - Freeze pending with ext_hold = 1 for 3 cycles: freeze stays 1, stall_count unchanged, entries static.
  - flush = 1 with ext_hold = 0 on a load issue: that load never appears, and a later read of its register gives select 0.
- Saturation and parameters:
  - Force 65 540 load-use cycles → stall_count = 16'hFFFF.
  - Re-run load-use with NSTAGE = 4, LOAD_READY_STAGE = 3 → 2 freeze cycles, then select 3.
